// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared sizes, FSM encoding and ψ row field helper for the Viterbi traceback
package viterbi_pkg;
    localparam int I = 8;
    localparam int N = 32;
    localparam int SW = $clog2(I);
    localparam int NW = $clog2(N);
    localparam int NW1 = NW + 1;
    localparam int RW = I * SW;
    localparam logic [NW:0] N_LEN = NW1'(N);

    typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_FIN} state_e;

    function automatic logic [SW-1:0] psi_field(input logic [RW-1:0] row, input logic [SW-1:0] j);
        return row[j*SW +: SW];
    endfunction
endpackage

// File: rtl/viterbi_traceback_if.sv
// viterbi_traceback_if: ψ write port, traceback control and decoded-state stream
interface viterbi_traceback_if;
    import viterbi_pkg::*;
    logic psi_wr_en;
    logic [NW-1:0] psi_wr_step;
    logic [RW-1:0] psi_wr_row;
    logic start;
    logic [NW:0] num_steps;
    logic [SW-1:0] final_state;
    logic busy;
    logic out_valid;
    logic out_ready;
    logic [SW-1:0] out_state;
    logic [NW-1:0] out_step;
    logic done;

    modport master (
        output psi_wr_en, psi_wr_step, psi_wr_row, start, num_steps, final_state, out_ready,
        input busy, out_valid, out_state, out_step, done
    );
    modport slave (
        input psi_wr_en, psi_wr_step, psi_wr_row, start, num_steps, final_state, out_ready,
        output busy, out_valid, out_state, out_step, done
    );
endinterface

// File: rtl/viterbi_psi_store.sv
// viterbi_psi_store: N x I backpointer array, one write port and a combinational read port
module viterbi_psi_store
    import viterbi_pkg::*;
(
    input  logic clk,
    input  logic wr_en,
    input  logic [NW-1:0] wr_step,
    input  logic [RW-1:0] wr_row,
    input  logic [NW-1:0] rd_step,
    input  logic [SW-1:0] rd_state,
    output logic [SW-1:0] rd_ptr
);
    logic [RW-1:0] mem_q [N];
    logic [RW-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_step] = wr_row;
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign rd_ptr = psi_field(mem_q[rd_step], rd_state);
endmodule

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: captures ψ rows and walks them backward from the terminal state, last step first
module viterbi_traceback
    import viterbi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    viterbi_traceback_if.slave bus
);
    state_e state_q, state_d;
    logic emit_q, emit_d;
    logic done_q, done_d;
    logic [SW-1:0] cur_q, cur_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW:0] t_eff;
    logic t_zero, last;
    logic [SW-1:0] back_ptr;

    viterbi_psi_store u_store (
        .clk(clk),
        .wr_en(bus.psi_wr_en && state_q == ST_IDLE),
        .wr_step(bus.psi_wr_step),
        .wr_row(bus.psi_wr_row),
        .rd_step(n_q),
        .rd_state(cur_q),
        .rd_ptr(back_ptr)
    );

    always_comb begin
        t_eff = bus.num_steps > N_LEN ? N_LEN : bus.num_steps;
        t_zero = bus.num_steps == '0;
        last = n_q == '0;
        state_d = state_q;
        emit_d = emit_q;
        done_d = 1'b0;
        cur_d = cur_q;
        n_d = n_q;
        if (state_q == ST_IDLE && bus.start) begin
            state_d = t_zero ? ST_FIN : ST_EMIT;
            emit_d = !t_zero;
            done_d = t_zero;
            cur_d = t_zero ? cur_q : bus.final_state;
            n_d = t_zero ? n_q : NW'(t_eff - 1'b1);
        end else if (state_q == ST_EMIT && bus.out_ready) begin
            state_d = last ? ST_FIN : ST_EMIT;
            emit_d = !last;
            done_d = last;
            cur_d = last ? cur_q : back_ptr;
            n_d = last ? n_q : n_q - 1'b1;
        end else if (state_q == ST_FIN) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            emit_q <= 1'b0;
            done_q <= 1'b0;
            cur_q <= '0;
            n_q <= '0;
        end else begin
            state_q <= state_d;
            emit_q <= emit_d;
            done_q <= done_d;
            cur_q <= cur_d;
            n_q <= n_d;
        end
    end

    assign bus.busy = emit_q;
    assign bus.out_valid = emit_q;
    assign bus.done = done_q;
    assign bus.out_state = cur_q;
    assign bus.out_step = n_q;
endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Back end of the Viterbi decoder.
- Captures the ψ backpointer rows produced each time-step by the per-state compute columns.
- On request, walks them backward from the terminal state and emits the most-likely state sequence, last step first, over a valid/ready stream.
- Sits between the column array (ψ producer) and the sequence consumer.

Parameters:
- I, 8, number of HMM states (power of two, ≥2)
- N, 32, maximum number of time-steps stored (power of two)
- SW, $clog2(I), state index width (derived, not overridden)
- NW, $clog2(N), step index width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- psi_wr_en  in  1  write one ψ row this cycle
- psi_wr_step  in  NW  time-step n of the row
- psi_wr_row  in  I*SW  ψ[n,j] for j=0..I-1; field j is bits [j*SW +: SW]
- start  in  1  one-cycle pulse: begin traceback
- num_steps  in  NW+1  sequence length T, sampled on start
- final_state  in  SW  argmax_j δ[T-1,j], sampled on start
- busy  out  1  traceback in progress
- out_valid  out  1  out_state/out_step valid
- out_ready  in  1  consumer accepts
- out_state  out  SW  decoded state s_n
- out_step  out  NW  time-step n of out_state
- done  out  1  one-cycle pulse: sequence complete

Behaviour:
- Reset (synchronous, active-high): busy, out_valid, done, out_state, out_step all 0; FSM to IDLE. ψ storage is not cleared (contents don't-care).
- Storage: N×I×SW register array.
  - Write occurs when psi_wr_en=1 and FSM=IDLE.
  - Writes while busy are dropped.
  - Row 0 is writable but never read.
- FSM IDLE:
  - start=1 and T≥1 → load n=min(T,N)-1, cur=final_state; go EMIT.
  - start=1 and T=0 → go FIN.
  - start with psi_wr_en in the same cycle: the write completes, and start is honoured.
- FSM EMIT:
  - busy=1, out_valid=1, out_state=cur, out_step=n.
  - Outputs hold stable while out_ready=0.
  - On out_valid&&out_ready with n>0 → cur ← ψ[n][cur], n ← n-1.
  - On handshake with n=0 → go FIN.
- FSM FIN:
  - done=1 and busy=0 for exactly one cycle; out_valid=0.
  - Next state IDLE.
- Latency:
  - First out_valid appears in the cycle after start.
  - With out_ready held high, one state per cycle; T states take T cycles.
  - done pulses in cycle T+1 after start.
- start while busy or in FIN is ignored.
- T>N is clamped to N.
- psi_wr_step is NW bits wide, so any out-of-range step cannot be encoded.
- Reset mid-traceback: next cycle out_valid=0, busy=0, no done pulse.

Decomposition:
- Package viterbi_pkg holds:
  - default I, N
  - derived SW, NW
  - FSM state encoding (IDLE, EMIT, FIN)
  - a helper for field extraction from a packed ψ row
- One sub-module, viterbi_psi_store:
  - ψ register array, single write port (en, step, row)
  - combinational read port (step, state) → SW-bit backpointer
- The traceback FSM, counters and stream logic live in the top.

Test Plan:
- Reset: assert rst 2 cycles mid-stream → busy=0, out_valid=0, done=0, out_state=0, out_step=0.
- Basic traceback:
  - Stimulus: write ψ[3][5]=2, ψ[2][2]=7, ψ[1][7]=0; start with T=4, final_state=5, out_ready=1.
  - Response: (step,state) = (3,5),(2,2),(1,7),(0,0) on consecutive cycles, then done for one cycle, busy low.
- Backpressure: same data, out_ready=0 for 3 cycles when (2,2) is presented → out_state=2, out_step=2 held for 3 cycles; sequence otherwise identical; done delayed by 3 cycles.
- Edge lengths:
  - T=1, final_state=6 → single output (0,6), then done.
  - T=0 → no out_valid, done pulse one cycle after the FSM leaves IDLE.
- Protection:
  - psi_wr_en to step 2 with new row during EMIT → emitted sequence unchanged.
  - Second start during EMIT → ignored.
  - rst during step 1 → out_valid=0 next cycle, no done.
- Clamp: write all rows ψ[n][j]=j, start T=40, final_state=3 → 32 outputs, steps 31..0, all state 3, then done.
